// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit byte input among NREQ packet sources. Arbitration
//   is round-robin, and a grant is held until the requester's last byte. An
//   optional header byte (HDR_BASE + index) starts every packet. At most BURST
//   bytes are written before the block waits for the UART buffer to drain.
//
// Ports
//   clk         single clock, shared with the UART byte input
//   resetn      asynchronous active-low reset
//   req_valid   per-requester byte valid
//   req_data    per-requester byte, requester i at [8i+7:8i]
//   req_last    per-requester last-byte-of-packet flag
//   req_ready   per-requester accept (only the granted index can be high)
//   o_din       byte to the UART
//   o_valid     one-cycle write strobe to the UART
//   i_tx_empty  UART transmit buffer empty flag
//   o_grant     one-hot locked requester, zero when idle
//   o_busy      high whenever the FSM is not in IDLE
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no packet locked; round-robin scan from r_ptr
// ST_HDR   | write the header byte for the locked requester
// ST_DATA  | forward bytes of the locked requester until its last byte
// ST_DRAIN | burst budget spent; guard period, then wait for UART empty
module uart_tx_arbiter #(
    parameter int         NREQ     = 4,
    parameter int         BURST    = 256,
    parameter int         HDR_EN   = 1,
    parameter logic [7:0] HDR_BASE = 8'hA0,
    parameter int         GUARD    = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        o_din,
    output logic              o_valid,
    input  logic              i_tx_empty,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [CW-1:0] BURST_C = CW'(BURST);
    localparam logic [GW-1:0] GUARD_C = GW'(GUARD);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DRAIN} state_t;

    state_t          r_state;
    state_t          r_ret;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_g;
    logic [CW-1:0]   r_burst_cnt;
    logic [GW-1:0]   r_guard_cnt;
    logic [7:0]      r_din;
    logic            r_valid;
    logic [NREQ-1:0] r_grant;

    logic            w_found;
    logic [PW-1:0]   w_pick;
    int              w_idx;
    logic            w_at_limit;
    logic            w_accept;
    logic [7:0]      w_data_sel;
    logic [CW-1:0]   w_cnt_inc;
    logic [PW-1:0]   w_g_next;

    // Rotating scan: first asserted request at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req_valid[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PW-1:0];
            end
        end
    end

    assign w_at_limit = (r_burst_cnt == BURST_C);
    assign w_data_sel = req_data[{r_g, 3'b000} +: 8];
    assign w_accept   = (r_state == ST_DATA) && !w_at_limit && req_valid[r_g];
    assign w_cnt_inc  = r_burst_cnt + CW'(1);
    assign w_g_next   = (r_g == PW'(NREQ - 1)) ? '0 : r_g + PW'(1);

    always_comb begin
        req_ready = '0;
        if (r_state == ST_DATA && !w_at_limit) req_ready[r_g] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ret       <= ST_IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_burst_cnt <= '0;
            r_guard_cnt <= '0;
            r_din       <= '0;
            r_valid     <= 1'b0;
            r_grant     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_g     <= w_pick;
                        r_grant <= NREQ'(1) << w_pick;
                        r_state <= (HDR_EN != 0) ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (w_at_limit) begin
                        r_state     <= ST_DRAIN;
                        r_ret       <= ST_HDR;
                        r_guard_cnt <= GUARD_C;
                    end else begin
                        r_din       <= HDR_BASE + {{(8-PW){1'b0}}, r_g};
                        r_valid     <= 1'b1;
                        r_burst_cnt <= w_cnt_inc;
                        r_state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_din       <= w_data_sel;
                        r_valid     <= 1'b1;
                        r_burst_cnt <= w_cnt_inc;
                        // A last byte ends the packet even when it also fills
                        // the burst; the next packet pays for the drain.
                        if (req_last[r_g]) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_g_next;
                            r_grant <= '0;
                        end else if (w_cnt_inc == BURST_C) begin
                            r_state     <= ST_DRAIN;
                            r_ret       <= ST_DATA;
                            r_guard_cnt <= GUARD_C;
                        end
                    end else if (w_at_limit) begin
                        r_state     <= ST_DRAIN;
                        r_ret       <= ST_DATA;
                        r_guard_cnt <= GUARD_C;
                    end
                end
                ST_DRAIN: begin
                    // The empty flag lags the last write, so ignore it until
                    // the guard counter has expired.
                    if (r_guard_cnt != '0) begin
                        r_guard_cnt <= r_guard_cnt - GW'(1);
                    end else if (i_tx_empty) begin
                        r_burst_cnt <= '0;
                        r_state     <= r_ret;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_din   = r_din;
    assign o_valid = r_valid;
    assign o_grant = r_grant;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte interface among NREQ independent packet sources, for example the debug, result and status streams.
- Arbitration is round-robin and packet-locked. An optional one-byte channel header is sent at the start of each packet.
- Bytes are issued in bursts of at most BURST. The block waits for the UART buffer to drain between bursts, so the UART never drops a byte.
- Sits between requester logic and the UART byte input (i_din/i_valid/o_empty), in the same clk domain as that byte input.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- BURST, 256: maximum bytes written between drain checks, headers included. Must be less than the UART buffer depth.
- HDR_EN, 1: 1 sends a header byte before each packet.
- HDR_BASE, 8'hA0: header value is HDR_BASE + granted index (8-bit wrap).
- GUARD, 3: cycles after the last write during which i_tx_empty is ignored. Covers the empty-flag lag.

Ports:
- clk, input, 1: single clock.
- resetn, input, 1: asynchronous, active-low reset.
- req_valid, input, NREQ: requester i has a byte on req_data.
- req_data, input, 8*NREQ: byte of requester i at bits [8i+7:8i].
- req_last, input, NREQ: byte of requester i is the last of its packet.
- req_ready, output, NREQ: byte of requester i is accepted this cycle when req_valid[i] is also high.
- o_din, output, 8: byte to the UART transmit input.
- o_valid, output, 1: one-cycle write strobe to the UART.
- i_tx_empty, input, 1: UART transmit buffer empty (o_empty of the UART).
- o_grant, output, NREQ: one-hot index of the currently locked requester; all zeros when idle.
- o_busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, resetn low):
  - Outputs: o_valid=0, o_din=0, o_grant=0, o_busy=0, req_ready=0.
  - State IDLE; priority pointer ptr=0; burst_cnt=0; guard_cnt=0.
- Reset mid-packet: the packet is abandoned with no further writes. The requester must restart its packet after reset.
- State machine has four states: IDLE, HDR, DATA, DRAIN.
- IDLE:
  - Scan req_valid starting at ptr, wrapping, and pick the first asserted index g.
  - Latch g and set o_grant=1<<g.
  - Go to HDR if HDR_EN, else DATA.
  - No request asserted: stay in IDLE.
- HDR:
  - If burst_cnt==BURST, go to DRAIN and return to HDR afterwards.
  - Otherwise write o_din=HDR_BASE+g with o_valid=1 for one cycle, increment burst_cnt, go to DATA.
- DATA:
  - req_ready[g] = (burst_cnt<BURST). All other ready bits are 0.
  - On req_valid[g]&&req_ready[g]: the next cycle has o_din=req_data[g] and o_valid=1 (1-cycle registered latency), and burst_cnt increments.
  - If the accepted byte has req_last[g]=1: go to IDLE, set ptr=(g+1) mod NREQ, clear o_grant.
  - If burst_cnt reaches BURST without last: go to DRAIN.
  - Any idle cycles from the requester are allowed; the lock is held.
- DRAIN:
  - guard_cnt counts GUARD cycles, measured from the last write strobe.
  - After that, wait for i_tx_empty==1.
  - On that cycle clear burst_cnt and return to the pending state (HDR or DATA).
- burst_cnt is not cleared at packet end. It is cleared only in DRAIN, so consecutive short packets still respect BURST.
- Throughput: at most one byte per cycle. A header costs one extra cycle per packet.
- Boundaries:
  - Simultaneous requests: the lowest index at or after ptr wins.
  - Single-byte packet (valid and last on the first byte) is legal.
  - req_last asserted on the byte that also fills BURST: the packet ends (state IDLE, burst_cnt stays at BURST). The next packet drains before it writes.
  - A requester that drops req_valid mid-packet keeps the lock indefinitely. There is no timeout.
  - Widths: burst_cnt is clog2(BURST+1) bits; ptr and g are clog2(NREQ) bits.
  - o_valid is never high in two states with the same data. Each accepted byte produces exactly one strobe.

Test Plan:
- Idle with no requests: hold all req_valid low for 100 cycles -> o_valid stays 0, o_busy=0, o_grant=0.
- Single packet: requester 2 sends 0x11, 0x22, 0x33 (last on 0x33) with HDR_EN=1 -> o_din sequence A2,11,22,33, one strobe each; o_grant=4'b0100 until 0x33 is accepted; ptr becomes 3.
- Round robin: all four requesters each hold a 2-byte packet from reset -> grant order 0,1,2,3. Issue a new request from 0 and 3 while 3 is active -> next grant is 0, then 3.
- Packet lock: requester 1 pauses valid for 10 cycles mid-packet while requester 0 is valid -> no grant change and no strobes until requester 1 finishes.
- Burst drain (BURST=8, HDR_EN=0): requester 0 sends 20 bytes; i_tx_empty is held low for 50 cycles, then high -> exactly 8 strobes, req_ready low for 3+50 cycles, then the next 8 bytes; 20 bytes total in order.
- Async reset mid-packet after byte 5: resetn pulsed low between clock edges -> o_valid and o_grant fall immediately. After release, a fresh request from requester 3 is granted starting with its header A3.
